// File: rtl/ram_arbiter_pkg.sv
// Shared encodings and defaults for the two-master RAM arbiter and its
// round-robin picker.
package ram_arbiter_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_ACK  = 2'd2
  } arb_state_e;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } arb_sel_e;

  function automatic arb_sel_e other_sel(input arb_sel_e s);
    return (s == SEL_A) ? SEL_B : SEL_A;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin picker: with both requesting, prio names the winner;
// otherwise the lone requester wins.
module rr_pick2
  import ram_arbiter_pkg::*;
(
  input  logic     req_a,
  input  logic     req_b,
  input  arb_sel_e prio,
  output logic     valid,
  output arb_sel_e sel
);

  always_comb begin
    valid = req_a | req_b;
    if (req_a && req_b) sel = prio;
    else if (req_b)     sel = SEL_B;
    else                sel = SEL_A;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin sequencer sharing one single-port RAM between two masters:
// IDLE picks a winner, BUSY performs the access, ACK returns the completion pulse.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [WIDTH-1:0]  wdata_a,
  output logic              gnt_a,
  output logic              ack_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  wdata_b,
  output logic              gnt_b,
  output logic              ack_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_in,
  input  logic [WIDTH-1:0]  mem_out
);

  arb_state_e state, state_next;
  arb_sel_e   sel, prio, pick_sel;
  logic       pick_valid;
  logic       busy, cur_we;

  rr_pick2 u_pick (
    .req_a (req_a),
    .req_b (req_b),
    .prio  (prio),
    .valid (pick_valid),
    .sel   (pick_sel)
  );

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: if (pick_valid) state_next = ARB_BUSY;
      ARB_BUSY: state_next = ARB_ACK;
      ARB_ACK:  state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  // Memory strobes are decoded from state, so an async reset drops them at once.
  always_comb begin
    busy     = (state == ARB_BUSY);
    cur_we   = (sel == SEL_B) ? we_b : we_a;
    mem_load = busy & cur_we;
    mem_addr = '0;
    mem_in   = '0;
    if (busy) begin
      mem_addr = (sel == SEL_B) ? addr_b  : addr_a;
      mem_in   = (sel == SEL_B) ? wdata_b : wdata_a;
    end
    gnt_a = (state == ARB_BUSY || state == ARB_ACK) && (sel == SEL_A);
    gnt_b = (state == ARB_BUSY || state == ARB_ACK) && (sel == SEL_B);
    ack_a = (state == ARB_ACK) && (sel == SEL_A);
    ack_b = (state == ARB_ACK) && (sel == SEL_B);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ARB_IDLE;
      sel   <= SEL_A;
      prio  <= SEL_A;
    end else begin
      state <= state_next;
      if (state == ARB_IDLE && pick_valid) sel  <= pick_sel;
      if (busy)                            prio <= other_sel(sel);
    end
  end

  // NOTE: the read-data holding registers are plain flops, so they are reset like any other state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else if (busy && !cur_we) begin
      if (sel == SEL_B) rdata_b <= mem_out;
      else              rdata_a <= mem_out;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM8 on the memory port;
// outputs are sampled on the falling edge.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, we_a, req_b, we_b;
  logic [2:0]  addr_a, addr_b;
  logic [15:0] wdata_a, wdata_b;
  logic        gnt_a, ack_a, gnt_b, ack_b;
  logic [15:0] rdata_a, rdata_b;
  logic        mem_load;
  logic [2:0]  mem_addr;
  logic [15:0] mem_in, mem_out;

  logic [15:0] ram [8];
  logic        ram_clr;

  int vectors     = 0;
  int miscompares = 0;
  int acks;

  always #5 clk = ~clk;

  ram_arbiter #(.WIDTH(16), .ADDR_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_a    (req_a),
    .we_a     (we_a),
    .addr_a   (addr_a),
    .wdata_a  (wdata_a),
    .gnt_a    (gnt_a),
    .ack_a    (ack_a),
    .rdata_a  (rdata_a),
    .req_b    (req_b),
    .we_b     (we_b),
    .addr_b   (addr_b),
    .wdata_b  (wdata_b),
    .gnt_b    (gnt_b),
    .ack_b    (ack_b),
    .rdata_b  (rdata_b),
    .mem_load (mem_load),
    .mem_addr (mem_addr),
    .mem_in   (mem_in),
    .mem_out  (mem_out)
  );

  // Word i starts as 16'h0A00 + i.
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 8; i++) ram[i] <= 16'h0A00 + 16'(i);
    end else if (mem_load) begin
      ram[mem_addr] <= mem_in;
    end
  end
  assign mem_out = ram[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"},  {30'd0, gnt_a, gnt_b}, 32'd0);
    check({tag, "_ack"},  {30'd0, ack_a, ack_b}, 32'd0);
    check({tag, "_load"}, {31'd0, mem_load}, 32'd0);
    check({tag, "_addr"}, {29'd0, mem_addr}, 32'd0);
    check({tag, "_in"},   {16'd0, mem_in}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; ram_clr = 1'b1;
    req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
    req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
    repeat (2) tick();
    check_idle_outputs("reset");
    check("reset_rdata_a", {16'd0, rdata_a}, 32'd0);
    check("reset_rdata_b", {16'd0, rdata_b}, 32'd0);
    reset = 1'b0; ram_clr = 1'b0;

    // Single write by A: BUSY in cycle 1, ack in cycle 2
    req_a = 1; we_a = 1; addr_a = 3'd3; wdata_a = 16'hBEEF;
    check("wr_c0_load", {31'd0, mem_load}, 32'd0);
    tick();
    check("wr_c1_load", {31'd0, mem_load}, 32'd1);
    check("wr_c1_addr", {29'd0, mem_addr}, 32'd3);
    check("wr_c1_in",   {16'd0, mem_in}, 32'hBEEF);
    check("wr_c1_gnt",  {30'd0, gnt_a, gnt_b}, 32'b10);
    check("wr_c1_ack",  {31'd0, ack_a}, 32'd0);
    tick();
    check("wr_c2_ack",  {30'd0, ack_a, ack_b}, 32'b10);
    check("wr_c2_load", {31'd0, mem_load}, 32'd0);
    check("wr_c2_addr", {29'd0, mem_addr}, 32'd0);
    req_a = 0; we_a = 0;
    tick();
    check_idle_outputs("wr_c3");
    check("wr_ram3", {16'd0, ram[3]}, 32'hBEEF);

    // Read back by B
    req_b = 1; we_b = 0; addr_b = 3'd3;
    tick();
    check("rd_c1_gnt",  {30'd0, gnt_a, gnt_b}, 32'b01);
    check("rd_c1_load", {31'd0, mem_load}, 32'd0);
    check("rd_c1_addr", {29'd0, mem_addr}, 32'd3);
    tick();
    check("rd_c2_ack",   {30'd0, ack_a, ack_b}, 32'b01);
    check("rd_c2_rdb",   {16'd0, rdata_b}, 32'hBEEF);
    check("rd_c2_rda",   {16'd0, rdata_a}, 32'd0);
    req_b = 0;
    tick();
    check("rd_c3_rdb_held", {16'd0, rdata_b}, 32'hBEEF);

    // Contention: A writes word 1, B reads word 3, both held for 12 cycles
    req_a = 1; we_a = 1; addr_a = 3'd1; wdata_a = 16'h1111;
    req_b = 1; we_b = 0; addr_b = 3'd3;
    acks = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      check($sformatf("cont_excl_%0d", t), {31'd0, gnt_a & gnt_b}, 32'd0);
      check($sformatf("cont_acka_%0d", t), {31'd0, ack_a},
            {31'd0, (t % 3 == 2) && (((t - 2) / 3) % 2 == 0)});
      check($sformatf("cont_ackb_%0d", t), {31'd0, ack_b},
            {31'd0, (t % 3 == 2) && (((t - 2) / 3) % 2 == 1)});
      if (ack_a || ack_b) acks++;
    end
    req_a = 0; we_a = 0; req_b = 0;
    check("cont_acks", acks, 32'd4);
    check("cont_ram1", {16'd0, ram[1]}, 32'h1111);
    check("cont_rdb",  {16'd0, rdata_b}, 32'hBEEF);
    check("cont_rda",  {16'd0, rdata_a}, 32'd0);

    // Priority after reset, then reset during A's ACK while prio points at B
    reset = 1'b1;
    #1;
    check("rst2_rdb", {16'd0, rdata_b}, 32'd0);
    tick();
    reset = 1'b0;
    req_a = 1; we_a = 0; addr_a = 3'd0;
    req_b = 1; we_b = 0; addr_b = 3'd2;
    tick();
    check("pri_first_gnt", {30'd0, gnt_a, gnt_b}, 32'b10);
    tick();
    check("pri_ack_a",   {30'd0, ack_a, ack_b}, 32'b10);
    check("pri_rdata_a", {16'd0, rdata_a}, 32'h0A00);
    #1 reset = 1'b1;
    #1;
    check("pri_ack_cut", {30'd0, ack_a, gnt_a}, 32'd0);
    check("pri_rda_clr", {16'd0, rdata_a}, 32'd0);
    #1 reset = 1'b0;
    tick();
    check("pri_again_gnt", {30'd0, gnt_a, gnt_b}, 32'b10);
    tick();
    check("pri_again_ack", {30'd0, ack_a, ack_b}, 32'b10);
    req_a = 0; req_b = 0;
    tick();

    // Reset during B's write BUSY cycle
    req_b = 1; we_b = 1; addr_b = 3'd5; wdata_b = 16'h1234;
    tick();
    check("rmw_busy_load", {31'd0, mem_load}, 32'd1);
    check("rmw_busy_addr", {29'd0, mem_addr}, 32'd5);
    #1 reset = 1'b1;
    #1;
    check_idle_outputs("rmw_rst");
    check("rmw_rda", {16'd0, rdata_a}, 32'd0);
    check("rmw_rdb", {16'd0, rdata_b}, 32'd0);
    req_b = 0; we_b = 0;
    tick();
    reset = 1'b0;
    check("rmw_ackb0", {31'd0, ack_b}, 32'd0);
    tick();
    check("rmw_ackb1", {31'd0, ack_b}, 32'd0);
    check("rmw_ram5",  {16'd0, ram[5]}, 32'h0A05);

    // Withdrawal: A pulses req for one cycle while B is in BUSY
    req_b = 1; we_b = 1; addr_b = 3'd6; wdata_b = 16'h6666;
    tick();
    check("wd_busy_gnt", {30'd0, gnt_a, gnt_b}, 32'b01);
    req_a = 1; we_a = 0; addr_a = 3'd0;
    tick();
    check("wd_ack_b", {30'd0, ack_a, ack_b}, 32'b01);
    req_a = 0; req_b = 0; we_b = 0;
    for (int t = 0; t < 3; t++) begin
      tick();
      check($sformatf("wd_no_a_%0d", t), {30'd0, gnt_a, ack_a}, 32'd0);
    end
    check("wd_ram6", {16'd0, ram[6]}, 32'h6666);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for one single-port RAM built from the register/Bit memory primitives.
- Requester A is the CPU data port; requester B is a secondary master (DMA or screen refresh).
- The block owns the memory's load, address and data-in lines, and returns read data and a one-cycle ack to whichever requester it served.

Parameters:
- WIDTH, 16, data word width (Hack word).
- ADDR_W, 3, memory address width (RAM8 default).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_a  input  1  requester A request; held high until ack_a.
- we_a  input  1  A write enable (1 = write, 0 = read); stable while req_a is high.
- addr_a  input  ADDR_W  A address; stable while req_a is high.
- wdata_a  input  WIDTH  A write data; stable while req_a is high.
- gnt_a  output  1  A owns the memory (BUSY or ACK state).
- ack_a  output  1  one-cycle completion pulse for A.
- rdata_a  output  WIDTH  A read data; valid while ack_a is high.
- req_b, we_b, addr_b, wdata_b, gnt_b, ack_b, rdata_b  same as A, for requester B.
- mem_load  output  1  memory load strobe; the write happens at the rising edge ending the cycle.
- mem_addr  output  ADDR_W  memory address.
- mem_in  output  WIDTH  memory write data.
- mem_out  input  WIDTH  memory combinational read data.

Behaviour:
- Reset:
  - state = IDLE, prio = A.
  - gnt_a, gnt_b, ack_a, ack_b, mem_load = 0.
  - mem_addr, mem_in = 0.
  - rdata_a, rdata_b registers = 0.
  - Reset takes effect asynchronously: all outputs go to reset values immediately, not at the next edge.
- States: IDLE, BUSY, ACK (2-bit encoding).
- IDLE:
  - No request: stay in IDLE.
  - Any req high: select a winner, latch sel, go to BUSY.
  - Both requests high: the requester named by prio wins.
- BUSY (1 cycle):
  - Drive mem_addr and mem_in from sel's inputs.
  - mem_load = sel's we; it is decoded combinationally from state and sel, so the write commits at the BUSY-ending edge.
  - On a read, capture mem_out into sel's rdata register at that same edge.
  - Toggle prio to the non-selected requester.
  - Go to ACK.
- ACK (1 cycle):
  - Assert sel's ack and gnt; mem_load = 0.
  - rdata holds the captured value; it is held after ACK until the next read by the same requester.
  - Go to IDLE unconditionally.
  - All req inputs are ignored in ACK.
- Latency:
  - req high in IDLE cycle n -> BUSY cycle n+1 -> ack in cycle n+2.
  - Minimum 3 cycles per transaction.
  - A requester that keeps req high after ack is treated as issuing a new request.
- Fairness:
  - With both requesting continuously, grants alternate A, B, A, B...
  - No requester waits more than one transaction.
- A requester dropping req while not granted: withdrawn, no effect.
- Dropping req while in BUSY or ACK: the transaction still completes.
- Only one gnt is high at any time; gnt_a and gnt_b are never both 1.
- mem_addr and mem_in = 0 outside BUSY.
- Reset during BUSY:
  - mem_load drops asynchronously, so no write occurs if reset is high at the edge.
  - No ack is issued.
  - prio returns to A.
- Reset during ACK: the ack pulse is cut short.

Decomposition:
- Shared header, `include'd alongside the memory primitives:
  - state encodings ARB_IDLE = 2'd0, ARB_BUSY = 2'd1, ARB_ACK = 2'd2;
  - select encodings SEL_A = 1'b0, SEL_B = 1'b1;
  - default WIDTH and ADDR_W constants.
- Sub-module rr_pick2 (combinational):
  - inputs: req_a, req_b, prio;
  - outputs: valid, sel.
- Keeping rr_pick2 separate allows reuse when more memory masters are added.

Test Plan:
- Single write: reset, then req_a = 1, we_a = 1, addr_a = 3, wdata_a = 16'hBEEF.
  - Required: mem_load = 1 only in cycle 1; ack_a in cycle 2.
  - Required: memory word 3 = BEEF afterwards.
- Read back: req_b = 1, we_b = 0, addr_b = 3 after the write above.
  - Required: ack_b 2 cycles later with rdata_b = 16'hBEEF.
  - Required: rdata_a unchanged.
- Contention: req_a and req_b both held high with distinct addresses for 12 cycles.
  - Required: grant order A, B, A, B; 4 acks total, each 3 cycles apart.
  - Required: gnt_a and gnt_b never both high.
- Priority after reset: both requests rise in the same cycle right after reset.
  - Required: A granted first.
  - Then assert reset mid-sequence and re-request both: A granted first again.
- Reset mid-write: reset asserted during B's BUSY cycle with wdata_b = 16'h1234, addr = 5.
  - Required: mem_load falls immediately and word 5 keeps its old value.
  - Required: no ack_b; all outputs return to 0.
- Withdrawal: req_a pulsed for one cycle while B is in BUSY.
  - Required: A is never granted and no ack_a occurs.
